// File: rtl/axi_lite_arbiter_2to1_if.sv
// AXI4-Lite channel bundle shared by the arbiter's upstream and downstream ports.
interface axi_lite_channel #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
);
    logic                   aw_valid;
    logic                   aw_ready;
    logic [AddrWidth-1:0]   aw_addr;
    logic [2:0]             aw_prot;
    logic                   w_valid;
    logic                   w_ready;
    logic [DataWidth-1:0]   w_data;
    logic [DataWidth/8-1:0] w_strb;
    logic                   b_valid;
    logic                   b_ready;
    logic [1:0]             b_resp;
    logic                   ar_valid;
    logic                   ar_ready;
    logic [AddrWidth-1:0]   ar_addr;
    logic [2:0]             ar_prot;
    logic                   r_valid;
    logic                   r_ready;
    logic [DataWidth-1:0]   r_data;
    logic [1:0]             r_resp;

    modport master (
        output aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
        output ar_valid, ar_addr, ar_prot, r_ready,
        input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
    );

    modport slave (
        input  aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
        input  ar_valid, ar_addr, ar_prot, r_ready,
        output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
    );
endinterface

// File: rtl/axi_lite_arbiter_2to1.sv
// Two-master AXI4-Lite arbiter onto one slave; independent write and read paths,
// one transaction outstanding per path, grant held from arbitration until the response.
module axi_lite_arbiter_2to1 #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input logic             clk,
    input logic             rstn,
    axi_lite_channel.slave  master0,
    axi_lite_channel.slave  master1,
    axi_lite_channel.master slave
);
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_RESP} r_state_e;

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;
    logic     wgnt_q, wgnt_d, wlast_q, wlast_d;
    logic     rgnt_q, rgnt_d, rlast_q, rlast_d;

    // Grant encoding: 0 = master0, 1 = master1.
    function automatic logic pick_gnt(input logic v0, input logic v1, input logic last);
        if (v0 && v1) return ROUND_ROBIN ? ~last : 1'b0;
        return v1;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            wgnt_q    <= 1'b0;
            rgnt_q    <= 1'b0;
            wlast_q   <= 1'b1;
            rlast_q   <= 1'b1;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            wgnt_q    <= wgnt_d;
            rgnt_q    <= rgnt_d;
            wlast_q   <= wlast_d;
            rlast_q   <= rlast_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        wgnt_d    = wgnt_q;
        wlast_d   = wlast_q;
        unique case (w_state_q)
            W_IDLE: if (master0.aw_valid || master1.aw_valid) begin
                wgnt_d    = pick_gnt(master0.aw_valid, master1.aw_valid, wlast_q);
                w_state_d = W_ADDR;
            end
            W_ADDR: if (slave.aw_valid && slave.aw_ready) w_state_d = W_DATA;
            W_DATA: if (slave.w_valid && slave.w_ready) w_state_d = W_RESP;
            W_RESP: if (slave.b_valid && slave.b_ready) begin
                w_state_d = W_IDLE;
                wlast_d   = wgnt_q;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        rgnt_d    = rgnt_q;
        rlast_d   = rlast_q;
        unique case (r_state_q)
            R_IDLE: if (master0.ar_valid || master1.ar_valid) begin
                rgnt_d    = pick_gnt(master0.ar_valid, master1.ar_valid, rlast_q);
                r_state_d = R_ADDR;
            end
            R_ADDR: if (slave.ar_valid && slave.ar_ready) r_state_d = R_RESP;
            R_RESP: if (slave.r_valid && slave.r_ready) begin
                r_state_d = R_IDLE;
                rlast_d   = rgnt_q;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Slave-side payloads follow the grant; only the handshake wires are state-gated.
    always_comb begin
        slave.aw_valid   = 1'b0;
        slave.aw_addr    = wgnt_q ? master1.aw_addr : master0.aw_addr;
        slave.aw_prot    = wgnt_q ? master1.aw_prot : master0.aw_prot;
        slave.w_valid    = 1'b0;
        slave.w_data     = wgnt_q ? master1.w_data : master0.w_data;
        slave.w_strb     = wgnt_q ? master1.w_strb : master0.w_strb;
        slave.b_ready    = 1'b0;
        master0.aw_ready = 1'b0;
        master0.w_ready  = 1'b0;
        master0.b_valid  = 1'b0;
        master0.b_resp   = 2'b00;
        master1.aw_ready = 1'b0;
        master1.w_ready  = 1'b0;
        master1.b_valid  = 1'b0;
        master1.b_resp   = 2'b00;
        unique case (w_state_q)
            W_ADDR: begin
                slave.aw_valid = wgnt_q ? master1.aw_valid : master0.aw_valid;
                if (wgnt_q) master1.aw_ready = slave.aw_ready;
                else        master0.aw_ready = slave.aw_ready;
            end
            W_DATA: begin
                slave.w_valid = wgnt_q ? master1.w_valid : master0.w_valid;
                if (wgnt_q) master1.w_ready = slave.w_ready;
                else        master0.w_ready = slave.w_ready;
            end
            W_RESP: begin
                slave.b_ready = wgnt_q ? master1.b_ready : master0.b_ready;
                if (wgnt_q) begin
                    master1.b_valid = slave.b_valid;
                    master1.b_resp  = slave.b_resp;
                end else begin
                    master0.b_valid = slave.b_valid;
                    master0.b_resp  = slave.b_resp;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        slave.ar_valid   = 1'b0;
        slave.ar_addr    = rgnt_q ? master1.ar_addr : master0.ar_addr;
        slave.ar_prot    = rgnt_q ? master1.ar_prot : master0.ar_prot;
        slave.r_ready    = 1'b0;
        master0.ar_ready = 1'b0;
        master0.r_valid  = 1'b0;
        master0.r_data   = '0;
        master0.r_resp   = 2'b00;
        master1.ar_ready = 1'b0;
        master1.r_valid  = 1'b0;
        master1.r_data   = '0;
        master1.r_resp   = 2'b00;
        unique case (r_state_q)
            R_ADDR: begin
                slave.ar_valid = rgnt_q ? master1.ar_valid : master0.ar_valid;
                if (rgnt_q) master1.ar_ready = slave.ar_ready;
                else        master0.ar_ready = slave.ar_ready;
            end
            R_RESP: begin
                slave.r_ready = rgnt_q ? master1.r_ready : master0.r_ready;
                if (rgnt_q) begin
                    master1.r_valid = slave.r_valid;
                    master1.r_data  = slave.r_data;
                    master1.r_resp  = slave.r_resp;
                end else begin
                    master0.r_valid = slave.r_valid;
                    master0.r_data  = slave.r_data;
                    master0.r_resp  = slave.r_resp;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_axi_lite_arbiter_2to1.sv
// Directed bench for axi_lite_arbiter_2to1: one round-robin instance and one
// fixed-priority instance, driven on the falling edge and checked 1 ns later.
module tb_axi_lite_arbiter_2to1;
    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    axi_lite_channel m0 ();
    axi_lite_channel m1 ();
    axi_lite_channel sl ();
    axi_lite_channel m0f ();
    axi_lite_channel m1f ();
    axi_lite_channel slf ();

    axi_lite_arbiter_2to1 #(.ROUND_ROBIN(1'b1)) dut_rr (
        .clk(clk), .rstn(rstn), .master0(m0), .master1(m1), .slave(sl)
    );
    axi_lite_arbiter_2to1 #(.ROUND_ROBIN(1'b0)) dut_fp (
        .clk(clk), .rstn(rstn), .master0(m0f), .master1(m1f), .slave(slf)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_m0_aw = 0;
    logic exp_g;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_all();
        m0.aw_valid = 0; m0.aw_addr = 0; m0.aw_prot = 0; m0.w_valid = 0; m0.w_data = 0;
        m0.w_strb = 0; m0.b_ready = 1; m0.ar_valid = 0; m0.ar_addr = 0; m0.ar_prot = 0;
        m0.r_ready = 1;
        m1.aw_valid = 0; m1.aw_addr = 0; m1.aw_prot = 0; m1.w_valid = 0; m1.w_data = 0;
        m1.w_strb = 0; m1.b_ready = 1; m1.ar_valid = 0; m1.ar_addr = 0; m1.ar_prot = 0;
        m1.r_ready = 1;
        sl.aw_ready = 0; sl.w_ready = 0; sl.b_valid = 0; sl.b_resp = 0; sl.ar_ready = 0;
        sl.r_valid = 0; sl.r_data = 0; sl.r_resp = 0;
        m0f.aw_valid = 0; m0f.aw_addr = 0; m0f.aw_prot = 0; m0f.w_valid = 0; m0f.w_data = 0;
        m0f.w_strb = 0; m0f.b_ready = 1; m0f.ar_valid = 0; m0f.ar_addr = 0; m0f.ar_prot = 0;
        m0f.r_ready = 1;
        m1f.aw_valid = 0; m1f.aw_addr = 0; m1f.aw_prot = 0; m1f.w_valid = 0; m1f.w_data = 0;
        m1f.w_strb = 0; m1f.b_ready = 1; m1f.ar_valid = 0; m1f.ar_addr = 0; m1f.ar_prot = 0;
        m1f.r_ready = 1;
        slf.aw_ready = 0; slf.w_ready = 0; slf.b_valid = 0; slf.b_resp = 0; slf.ar_ready = 0;
        slf.r_valid = 0; slf.r_data = 0; slf.r_resp = 0;
    endtask

    task automatic check_all_quiet(input string tag);
        check_eq(tag, 32'({sl.aw_valid, sl.w_valid, sl.b_ready, sl.ar_valid, sl.r_ready,
                           m0.aw_ready, m0.w_ready, m0.b_valid, m0.ar_ready, m0.r_valid,
                           m1.aw_ready, m1.w_ready, m1.b_valid, m1.ar_ready, m1.r_valid}),
                 32'h0);
    endtask

    initial begin
        idle_all();
        #2 rstn = 1'b0;
        // Live requests and responses while in reset must not leak through.
        m0.aw_valid = 1; m0.w_valid = 1; m1.ar_valid = 1;
        sl.aw_ready = 1; sl.w_ready = 1; sl.b_valid = 1; sl.ar_ready = 1; sl.r_valid = 1;
        repeat (2) @(negedge clk);
        #1 check_all_quiet("reset outputs");
        idle_all();
        @(negedge clk) rstn = 1'b1;

        // Single write from master0.
        @(negedge clk);
        m0.aw_valid = 1; m0.aw_addr = 32'h10; m0.w_valid = 1; m0.w_data = 32'hA5A5A5A5;
        m0.w_strb = 4'hF; sl.aw_ready = 1; sl.w_ready = 1;
        #1 check_eq("wr arb cycle s.aw_valid", 32'(sl.aw_valid), 32'h0);
        @(negedge clk); #1;
        check_eq("wr s.aw_valid", 32'(sl.aw_valid), 32'h1);
        check_eq("wr s.aw_addr", sl.aw_addr, 32'h10);
        check_eq("wr m0.aw_ready", 32'(m0.aw_ready), 32'h1);
        check_eq("wr m1.aw_ready", 32'(m1.aw_ready), 32'h0);
        check_eq("wr s.w_valid early", 32'(sl.w_valid), 32'h0);
        @(negedge clk); m0.aw_valid = 0; #1;
        check_eq("wr s.w_valid", 32'(sl.w_valid), 32'h1);
        check_eq("wr s.w_data", sl.w_data, 32'hA5A5A5A5);
        check_eq("wr s.w_strb", 32'(sl.w_strb), 32'hF);
        check_eq("wr m0.w_ready", 32'(m0.w_ready), 32'h1);
        check_eq("wr m1.w_ready", 32'(m1.w_ready), 32'h0);
        @(negedge clk); m0.w_valid = 0; sl.b_valid = 1; sl.b_resp = 2'b00; #1;
        check_eq("wr m0.b_valid", 32'(m0.b_valid), 32'h1);
        check_eq("wr m0.b_resp", 32'(m0.b_resp), 32'h0);
        check_eq("wr s.b_ready", 32'(sl.b_ready), 32'h1);
        check_eq("wr m1.b_valid", 32'(m1.b_valid), 32'h0);
        @(negedge clk); sl.b_valid = 0; #1;
        check_eq("wr done m0.b_valid", 32'(m0.b_valid), 32'h0);

        // Round-robin reads with both masters requesting continuously.
        @(negedge clk);
        m0.ar_valid = 1; m0.ar_addr = 32'h100; m1.ar_valid = 1; m1.ar_addr = 32'h200;
        sl.ar_ready = 1;
        for (int i = 0; i < 4; i++) begin
            exp_g = i[0];
            @(negedge clk); #1;
            check_eq("rr s.ar_valid", 32'(sl.ar_valid), 32'h1);
            check_eq("rr s.ar_addr", sl.ar_addr, exp_g ? 32'h200 : 32'h100);
            check_eq("rr m0.ar_ready", 32'(m0.ar_ready), 32'(!exp_g));
            check_eq("rr m1.ar_ready", 32'(m1.ar_ready), 32'(exp_g));
            @(negedge clk); sl.r_valid = 1; sl.r_data = 32'hD0 + 32'(i); #1;
            check_eq("rr m0.r_valid", 32'(m0.r_valid), 32'(!exp_g));
            check_eq("rr m1.r_valid", 32'(m1.r_valid), 32'(exp_g));
            check_eq("rr m0.r_data", m0.r_data, exp_g ? 32'h0 : 32'hD0 + 32'(i));
            check_eq("rr m1.r_data", m1.r_data, exp_g ? 32'hD0 + 32'(i) : 32'h0);
            @(negedge clk); sl.r_valid = 0;
            if (i == 3) begin
                m0.ar_valid = 0; m1.ar_valid = 0;
            end
        end

        // Concurrent write (master0) and read (master1), with a late write response.
        @(negedge clk);
        m0.aw_valid = 1; m0.aw_addr = 32'h20; m0.w_valid = 1; m0.w_data = 32'h11223344;
        m1.ar_valid = 1; m1.ar_addr = 32'h30;
        @(negedge clk); #1;
        check_eq("cc s.aw_valid", 32'(sl.aw_valid), 32'h1);
        check_eq("cc s.ar_valid", 32'(sl.ar_valid), 32'h1);
        check_eq("cc s.ar_addr", sl.ar_addr, 32'h30);
        check_eq("cc m1.ar_ready", 32'(m1.ar_ready), 32'h1);
        check_eq("cc m0.ar_ready", 32'(m0.ar_ready), 32'h0);
        @(negedge clk); m0.aw_valid = 0; m1.ar_valid = 0; #1;
        check_eq("cc s.w_valid", 32'(sl.w_valid), 32'h1);
        check_eq("cc m1.r_valid idle", 32'(m1.r_valid), 32'h0);
        @(negedge clk); m0.w_valid = 0; sl.r_valid = 1; sl.r_data = 32'hCAFE0001; #1;
        check_eq("cc s.b_ready", 32'(sl.b_ready), 32'h1);
        check_eq("cc m0.b_valid wait", 32'(m0.b_valid), 32'h0);
        check_eq("cc m1.r_valid", 32'(m1.r_valid), 32'h1);
        check_eq("cc m1.r_data", m1.r_data, 32'hCAFE0001);
        repeat (4) begin
            @(negedge clk); sl.r_valid = 0; #1;
            check_eq("cc b wait m0.b_valid", 32'(m0.b_valid), 32'h0);
            check_eq("cc b wait s.b_ready", 32'(sl.b_ready), 32'h1);
            check_eq("cc read idle s.r_ready", 32'(sl.r_ready), 32'h0);
        end
        @(negedge clk); sl.b_valid = 1; sl.b_resp = 2'b10; #1;
        check_eq("cc m0.b_valid", 32'(m0.b_valid), 32'h1);
        check_eq("cc m0.b_resp", 32'(m0.b_resp), 32'h2);
        @(negedge clk); sl.b_valid = 0; sl.b_resp = 2'b00;

        // Read response backpressure from master1.
        @(negedge clk); m1.ar_valid = 1; m1.ar_addr = 32'h40; m1.r_ready = 0;
        @(negedge clk); #1;
        check_eq("bp m1.ar_ready", 32'(m1.ar_ready), 32'h1);
        @(negedge clk); m1.ar_valid = 0; sl.r_valid = 1; sl.r_data = 32'hBEEF0042;
        repeat (3) begin
            #1;
            check_eq("bp s.r_ready", 32'(sl.r_ready), 32'h0);
            check_eq("bp m1.r_valid", 32'(m1.r_valid), 32'h1);
            check_eq("bp m1.r_data", m1.r_data, 32'hBEEF0042);
            @(negedge clk);
        end
        m1.r_ready = 1; #1;
        check_eq("bp release s.r_ready", 32'(sl.r_ready), 32'h1);
        check_eq("bp release m1.r_data", m1.r_data, 32'hBEEF0042);
        @(negedge clk); sl.r_valid = 0; #1;
        check_eq("bp done m1.r_valid", 32'(m1.r_valid), 32'h0);

        // Reset while a write sits in the data phase.
        @(negedge clk);
        m0.aw_valid = 1; m0.aw_addr = 32'h50; m0.w_valid = 1; m0.w_data = 32'h55; sl.w_ready = 0;
        @(negedge clk); #1;
        check_eq("rst-mid s.aw_valid", 32'(sl.aw_valid), 32'h1);
        @(negedge clk); m0.aw_valid = 0; #1;
        check_eq("rst-mid s.w_valid", 32'(sl.w_valid), 32'h1);
        #1;
        sl.w_ready = 1; sl.b_valid = 1; sl.r_valid = 1; rstn = 1'b0;
        #1 check_all_quiet("rst-mid outputs");
        idle_all();
        @(negedge clk);
        @(negedge clk) rstn = 1'b1;
        @(negedge clk);
        m0.aw_valid = 1; m0.aw_addr = 32'h60; m1.aw_valid = 1; m1.aw_addr = 32'h70;
        sl.aw_ready = 1;
        @(negedge clk); #1;
        check_eq("post-rst m0.aw_ready", 32'(m0.aw_ready), 32'h1);
        check_eq("post-rst m1.aw_ready", 32'(m1.aw_ready), 32'h0);
        check_eq("post-rst s.aw_addr", sl.aw_addr, 32'h60);
        @(negedge clk); idle_all();

        // Fixed priority: master0 wins every round, master1 never gets aw_ready.
        @(negedge clk);
        m0f.aw_valid = 1; m0f.aw_addr = 32'h80; m0f.w_valid = 1;
        m1f.aw_valid = 1; m1f.aw_addr = 32'h90; m1f.w_valid = 1;
        slf.aw_ready = 1; slf.w_ready = 1; slf.b_valid = 1;
        for (int c = 0; c < 12; c++) begin
            #1;
            check_eq("fp m1.aw_ready", 32'(m1f.aw_ready), 32'h0);
            if (m0f.aw_ready) n_m0_aw++;
            @(negedge clk);
        end
        check_eq("fp m0 grant count", 32'(n_m0_aw), 32'h3);
        idle_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/axi_lite_arbiter_2to1.md
AXI_LITE_ARBITER_2TO1 -- requirements
Module: axi_lite_arbiter_2to1

Interface
REQ-001 Parameter ROUND_ROBIN, default 1, meaning 1 = round-robin arbitration, 0 = fixed priority with master0 winning.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 master0  axi_lite_channel.slave  interface width  upstream requester 0.
REQ-005 master1  axi_lite_channel.slave  interface width  upstream requester 1.
REQ-006 slave  axi_lite_channel.master  interface width  shared downstream target.
REQ-007 The module SHALL take clock and reset from clk and rstn only, never from the interface signals.

Function -- write path
REQ-008 The write path SHALL use the FSM states W_IDLE, W_ADDR, W_DATA and W_RESP, with one write outstanding at a time.
REQ-009 In W_IDLE, when any master asserts aw_valid, the FSM SHALL register the grant (wgnt) and go to W_ADDR on the next edge; this costs 1 arbitration cycle.
REQ-010 With both aw_valid high and ROUND_ROBIN=1, the grant SHALL go to the master not granted last (wlast); with ROUND_ROBIN=0 it SHALL go to master0.
REQ-011 In W_ADDR, slave.aw_valid/aw_addr/aw_prot SHALL follow the granted master and its aw_ready SHALL follow slave.aw_ready; on the AW handshake the FSM SHALL go to W_DATA.
REQ-012 In W_DATA, slave.w_valid/w_data/w_strb SHALL follow the granted master and its w_ready SHALL follow slave.w_ready; on the W handshake the FSM SHALL go to W_RESP.
REQ-013 In W_RESP, the granted master's b_valid/b_resp SHALL follow the slave and slave.b_ready SHALL follow its b_ready; on the B handshake the FSM SHALL go to W_IDLE and set wlast to wgnt.
REQ-014 The non-granted master SHALL see aw_ready, w_ready and b_valid at 0; in states where a channel is not forwarded, slave valid/ready on that channel SHALL be 0.

Function -- read path
REQ-015 The read path SHALL use the FSM states R_IDLE, R_ADDR and R_RESP, independent of the write path, with one read outstanding at a time.
REQ-016 In R_IDLE, when any ar_valid is high, the FSM SHALL register the grant (rgnt) using the rule of REQ-010 with rlast, and go to R_ADDR.
REQ-017 In R_ADDR, the AR channel SHALL be routed as in REQ-011; on the AR handshake the FSM SHALL go to R_RESP.
REQ-018 In R_RESP, r_valid/r_data/r_resp SHALL go to the granted master and r_ready back to the slave; on the R handshake the FSM SHALL go to R_IDLE and set rlast to rgnt.
REQ-019 The non-granted master SHALL see ar_ready=0 and r_valid=0.
REQ-020 A write and a read SHALL be able to proceed concurrently, with either master granted on either path.
REQ-021 The grant SHALL be stable from the arbitration edge until the return to IDLE; a requester dropping or adding valid SHALL NOT change it.
REQ-022 All routing SHALL be combinational from the registered state and grant, with no added pipeline stage beyond the arbitration cycle.

Reset
REQ-023 While rstn is low, the FSMs SHALL be in W_IDLE/R_IDLE, and wlast and rlast SHALL be 1 so that master0 wins the first contention.
REQ-024 During reset, every ready/valid output on all three interfaces SHALL be 0.
REQ-025 Reset asserted mid-transaction SHALL abandon the transaction immediately (asynchronously); the bench SHALL not expect completion.

Verification
REQ-026 Single write: master0 sends AW addr 0x10 and W data 0xA5A5A5A5 with strb 0xF; the slave accepts at once and returns b_resp OKAY. Required: slave.aw_valid rises 1 cycle after master0.aw_valid; master0 gets b_valid with OKAY; master1 sees no handshake.
REQ-027 Contention, ROUND_ROBIN=1: both masters hold ar_valid continuously for 4 reads. Required: grant order m0, m1, m0, m1, and each r_data is returned only to its requester.
REQ-028 Contention, ROUND_ROBIN=0: both masters hold aw_valid continuously. Required: master0 wins every arbitration and master1 stays stalled with aw_ready=0.
REQ-029 Concurrency: master0 writes while master1 reads, and the slave delays b_valid by 5 cycles. Required: the read completes while the write waits in W_RESP.
REQ-030 Backpressure: the slave holds r_ready-side r_valid high while master1 holds r_ready=0 for 3 cycles. Required: slave.r_ready=0 for those cycles, and r_data is stable until the handshake.
REQ-031 Reset mid-W_DATA: pull rstn low. Required: all valid/ready outputs are 0 in the same cycle; after release, master0 wins the first contention.
